// File: rtl/paint_pkg.sv
`default_nettype none
// ============================================================================
// Module      : paint_pkg
// Description : Constants and types shared by the paint / camera frame-buffer
//               datapath. The frame buffer is 640x480 words. Each word is
//               9 bits: RGB 3:3:3, or a zero-extended grayscale byte.
// Revision    : 1.0 - initial release
// ============================================================================
package paint_pkg;

  localparam int H_RES      = 640;
  localparam int V_RES      = 480;
  localparam int NUM_PIXELS = H_RES * V_RES;

  typedef logic [8:0] pixel_word_t;

  // Write-port owner: CLEAR while the sweep runs, RUN while writers are arbitrated
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/frame_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_write_arbiter_if
// Description : Writer-side and memory-side bus of the frame write arbiter.
//   cam_we/cam_addr/cam_pixel        : camera pixel strobe, no backpressure
//   cur_valid/cur_ready/cur_addr/rgb : cursor brush write handshake
//   mem_we/mem_addr/mem_data         : registered write port to ram_2port
//   modport master : writers and memory (source of requests)
//   modport slave  : the arbiter
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_write_arbiter_if
  import paint_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 9
);

  logic              cam_we;
  logic [ADDR_W-1:0] cam_addr;
  logic [7:0]        cam_pixel;
  logic              cur_valid;
  logic              cur_ready;
  logic [ADDR_W-1:0] cur_addr;
  pixel_word_t       cur_rgb;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  modport master (
    output cam_we, cam_addr, cam_pixel, cur_valid, cur_addr, cur_rgb,
    input  cur_ready, mem_we, mem_addr, mem_data
  );

  modport slave (
    input  cam_we, cam_addr, cam_pixel, cur_valid, cur_addr, cur_rgb,
    output cur_ready, mem_we, mem_addr, mem_data
  );

endinterface
`default_nettype wire

// File: rtl/frame_write_arbiter_clear_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : clear_sweeper
// Description : Owns the CLEAR/RUN state of the frame write port. While in
//               CLEAR it walks sweep_addr through 0..NUM_PIXELS-1, one
//               address per cycle. After the last address it enters RUN.
//               A start pulse re-enters CLEAR at address 0 from any state.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : single-cycle sweep request
//   state        : CLEAR while sweeping, RUN otherwise
//   sweep_addr   : address to clear this cycle (valid in CLEAR)
//   done         : high once a sweep has completed and none is running
// Revision    : 1.0 - initial release
// ============================================================================
module clear_sweeper #(
  parameter int ADDR_W     = 20,
  parameter int NUM_PIXELS = paint_pkg::NUM_PIXELS
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             start,
  output paint_pkg::arb_state_t state,
  output logic [ADDR_W-1:0]     sweep_addr,
  output logic                  done
);

  localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  paint_pkg::arb_state_t r_state, w_state_nxt;
  logic [ADDR_W-1:0]     r_count, w_count_nxt;
  logic                  r_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= paint_pkg::CLEAR;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      // done lags the state by one cycle. It rises in the cycle after the
      // last sweep write appears on the memory port.
      r_done  <= !start && (r_state == paint_pkg::RUN);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    if (start) begin
      w_state_nxt = paint_pkg::CLEAR;
      w_count_nxt = '0;
    end else if (r_state == paint_pkg::CLEAR) begin
      if (r_count == C_LAST_ADDR) begin
        w_state_nxt = paint_pkg::RUN;
        w_count_nxt = '0;
      end else begin
        w_count_nxt = r_count + ADDR_W'(1);
      end
    end
  end

  assign state      = r_state;
  assign sweep_addr = r_count;
  assign done       = r_done;

endmodule
`default_nettype wire

// File: rtl/frame_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : frame_write_arbiter
// Description : Single registered write port of the frame buffer. It is shared
//               by the clear sweep, the camera stream (which has a one-entry
//               skid) and the cursor brush (which has starvation protection).
//   clk, reset_n : CLOCK_50, asynchronous active-low reset
//   clear_req    : pulse, restarts the clear sweep from address 0
//   mode         : 0 = paint (camera ignored), 1 = camera view
//   bus          : camera / cursor / memory signals (slave modport)
//   init_done    : a sweep has completed and none is running
//   drop_count   : saturating count of camera pixels lost to overflow
// Revision    : 1.0 - initial release
// ============================================================================
module frame_write_arbiter #(
  parameter int ADDR_W       = 20,
  parameter int DATA_W       = 9,
  parameter int NUM_PIXELS   = paint_pkg::NUM_PIXELS,
  parameter int STARVE_LIMIT = 8,
  parameter int CLEAR_VALUE  = 0
) (
  input  wire logic                  clk,
  input  wire logic                  reset_n,
  input  wire logic                  clear_req,
  input  wire logic                  mode,
  frame_write_arbiter_if.slave       bus,
  output logic                       init_done,
  output logic [7:0]                 drop_count
);

  localparam int              WAIT_W     = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] C_WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  paint_pkg::arb_state_t w_state;
  logic [ADDR_W-1:0]     w_sweep_addr;
  logic                  w_sweep_done;

  logic                  r_skid_full;
  logic [ADDR_W-1:0]     r_skid_addr;
  logic [DATA_W-1:0]     r_skid_data;
  logic [WAIT_W-1:0]     r_wait;
  logic [7:0]            r_drop;
  logic                  r_mem_we;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [DATA_W-1:0]     r_mem_data;

  logic                  w_cam_live;
  logic                  w_starved;
  logic                  w_grant_we;
  logic [ADDR_W-1:0]     w_grant_addr;
  logic [DATA_W-1:0]     w_grant_data;
  logic                  w_cur_grant;
  logic                  w_skid_load;
  logic                  w_skid_pop;
  logic                  w_drop;

  clear_sweeper #(
    .ADDR_W     (ADDR_W),
    .NUM_PIXELS (NUM_PIXELS)
  ) u_sweeper (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (clear_req),
    .state      (w_state),
    .sweep_addr (w_sweep_addr),
    .done       (w_sweep_done)
  );

  assign w_cam_live = mode && bus.cam_we;
  // The wait counter saturates at the limit, so equality means "starved".
  assign w_starved  = (r_wait == C_WAIT_MAX) && bus.cur_valid;

  // A forced cursor write wins even over a full skid. Otherwise a camera
  // stream at full clock rate would refill the skid every cycle and lock the
  // cursor out indefinitely. The price is the strobe that arrives during the
  // forced grant: it is dropped if the skid is still occupied. When the skid
  // drains, it takes the same-cycle camera strobe, so continuous streaming
  // does not lose pixels.
  always_comb begin
    w_grant_we   = 1'b0;
    w_grant_addr = '0;
    w_grant_data = '0;
    w_cur_grant  = 1'b0;
    w_skid_load  = 1'b0;
    w_skid_pop   = 1'b0;
    w_drop       = 1'b0;
    if (w_state != paint_pkg::RUN) begin
      w_grant_we   = 1'b1;
      w_grant_addr = w_sweep_addr;
      w_grant_data = DATA_W'(CLEAR_VALUE);
    end else if (w_starved) begin
      w_cur_grant = 1'b1;
      if (w_cam_live) begin
        if (r_skid_full) w_drop = 1'b1;
        else             w_skid_load = 1'b1;
      end
    end else if (r_skid_full) begin
      w_grant_we   = 1'b1;
      w_grant_addr = r_skid_addr;
      w_grant_data = r_skid_data;
      w_skid_pop   = 1'b1;
      w_skid_load  = w_cam_live;
    end else if (w_cam_live) begin
      w_grant_we   = 1'b1;
      w_grant_addr = bus.cam_addr;
      w_grant_data = DATA_W'(bus.cam_pixel);
    end else if (bus.cur_valid) begin
      w_cur_grant = 1'b1;
    end
    if (w_cur_grant) begin
      w_grant_we   = 1'b1;
      w_grant_addr = bus.cur_addr;
      w_grant_data = DATA_W'(bus.cur_rgb);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_skid_full <= 1'b0;
      r_skid_addr <= '0;
      r_skid_data <= '0;
      r_wait      <= '0;
      r_drop      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
    end else begin
      if (clear_req) begin
        r_skid_full <= 1'b0;
      end else if (w_skid_load) begin
        r_skid_full <= 1'b1;
        r_skid_addr <= bus.cam_addr;
        r_skid_data <= DATA_W'(bus.cam_pixel);
      end else if (w_skid_pop) begin
        r_skid_full <= 1'b0;
      end

      if (w_cur_grant)
        r_wait <= '0;
      else if (bus.cur_valid && (r_wait != C_WAIT_MAX))
        r_wait <= r_wait + WAIT_W'(1);

      if (w_drop && (r_drop != 8'hFF))
        r_drop <= r_drop + 8'd1;

      r_mem_we <= w_grant_we;
      if (w_grant_we) begin
        r_mem_addr <= w_grant_addr;
        r_mem_data <= w_grant_data;
      end
    end
  end

  assign bus.cur_ready = w_cur_grant;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_data  = r_mem_data;
  assign init_done     = w_sweep_done;
  assign drop_count    = r_drop;

endmodule
`default_nettype wire
